// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one Q15 fixed-point unit among NREQ requesters, one op in flight.
// Optional macro FPU_ARB_NAN_FLAG_EN enables the rsp_nan result flag (tied 0 when undefined).
module fpu_issue_arbiter #(
  parameter int NREQ        = 2,
  parameter int IDW         = 1,
  parameter int DIV_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic [3:0]           fpu_op,
  output logic [63:0]          fpu_a,
  output logic [63:0]          fpu_b,
  input  logic                 fpu_busy,
  input  logic [63:0]          fpu_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 rsp_nan,
  output logic [2:0]           dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i]; a response
  // transfers on rsp_valid & rsp_ready, and rsp_* fields hold steady while rsp_valid waits.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_DIV_START = 3'd2,
    S_DIV_WAIT  = 3'd3,
    S_ERR_RESP  = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  localparam logic [3:0]  OP_DIV       = 4'b0011;
  localparam logic [16:0] TIMEOUT_LAST = 17'(DIV_TIMEOUT);

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [3:0]      op_q;
  logic [63:0]     a_q, b_q;
  logic [IDW-1:0]  id_q;
  logic [63:0]     data_q;
  logic            err_q;
  logic [15:0]     div_cnt;
  logic            seen_busy;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [3:0]      sel_op;
  logic [63:0]     sel_a, sel_b;
  logic            div_done, div_timeout;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0111, 4'b1011, 4'b1110, 4'b1111: op_legal = 1'b0;
      default:                            op_legal = 1'b1;
    endcase
  endfunction

  // Later assignments win: indices at/after rr_ptr override the wrapped ones, lowest first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) < rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[64*i +: 64];
        sel_b  = req_b[64*i +: 64];
      end
    end
  end

  // The unit raises busy only after launch, so completion needs at least one busy cycle first.
  assign div_done    = (state == S_DIV_WAIT) && !fpu_busy && seen_busy;
  assign div_timeout = (state == S_DIV_WAIT) && !div_done &&
                       (({1'b0, div_cnt} + 17'd1) >= TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    fpu_op     = 4'b0000;
    fpu_a      = '0;
    fpu_b      = '0;
    case (state)
      S_IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = grant_found && (grant_idx == IDW'(i));
        end
        if (grant_found) begin
          if (!op_legal(sel_op))     state_next = S_ERR_RESP;
          else if (sel_op == OP_DIV) state_next = S_DIV_START;
          else                       state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        fpu_op     = op_q;
        fpu_a      = a_q;
        fpu_b      = b_q;
        state_next = S_RESP;
      end
      S_DIV_START: begin
        fpu_op = OP_DIV;
        fpu_a  = a_q;
        fpu_b  = b_q;
        if (!fpu_busy) state_next = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        fpu_op = OP_DIV;
        fpu_a  = a_q;
        fpu_b  = b_q;
        if (div_done || div_timeout) state_next = S_RESP;
      end
      S_ERR_RESP: state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      div_cnt   <= '0;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= grant_idx;
            data_q <= '0;
            err_q  <= 1'b0;
          end
        end
        S_EXEC: data_q <= fpu_res;
        S_DIV_START: begin
          div_cnt   <= '0;
          seen_busy <= 1'b0;
        end
        S_DIV_WAIT: begin
          div_cnt <= div_cnt + 16'd1;
          if (fpu_busy) seen_busy <= 1'b1;
          if (div_done) begin
            data_q <= fpu_res;
          end else if (div_timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        S_ERR_RESP: begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ARB_NAN_FLAG_EN
  localparam logic [63:0] NAN_CODE = 64'h8000_0000_0000_0000;
  logic nan_q;

  // Divide timeouts report as NaN alongside the saturated-result code.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nan_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:     if (grant_found) nan_q <= 1'b0;
        S_EXEC:     nan_q <= (fpu_res == NAN_CODE);
        S_DIV_WAIT: begin
          if (div_done)         nan_q <= (fpu_res == NAN_CODE);
          else if (div_timeout) nan_q <= 1'b1;
        end
        S_ERR_RESP: nan_q <= 1'b0;
        default: ;
      endcase
    end
  end
  assign rsp_nan = nan_q;
`else
  assign rsp_nan = 1'b0;
`endif

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter: drivers push expected responses, monitors pop and compare.
module tb_fpu_issue_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int W    = 67;
`ifdef FPU_ARB_NAN_FLAG_EN
  localparam logic NAN_EN = 1'b1;
`else
  localparam logic NAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [64*NREQ-1:0] req_a, req_b;
  logic [3:0]         fpu_op;
  logic [63:0]        fpu_a, fpu_b, fpu_res, rsp_data;
  logic               fpu_busy, rsp_valid, rsp_ready, rsp_err, rsp_nan;
  logic [IDW-1:0]     rsp_id;
  logic [2:0]         dbg_state;

  logic [NREQ-1:0]    req_valid2, req_ready2;
  logic [4*NREQ-1:0]  req_op2;
  logic [64*NREQ-1:0] req_a2, req_b2;
  logic [3:0]         fpu_op2;
  logic [63:0]        fpu_a2, fpu_b2, fpu_res2, rsp_data2;
  logic               fpu_busy2, rsp_valid2, rsp_ready2, rsp_err2, rsp_nan2;
  logic [IDW-1:0]     rsp_id2;
  logic [2:0]         dbg_state2;

  fpu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .DIV_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_busy(fpu_busy), .fpu_res(fpu_res), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_nan(rsp_nan), .dbg_state(dbg_state)
  );

  fpu_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .DIV_TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op2), .req_a(req_a2), .req_b(req_b2), .fpu_op(fpu_op2), .fpu_a(fpu_a2),
    .fpu_b(fpu_b2), .fpu_busy(fpu_busy2), .fpu_res(fpu_res2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .rsp_nan(rsp_nan2), .dbg_state(dbg_state2)
  );

  // Stand-in for the fixed-point unit: Q15 add/sub/mul/div, pass-through, xor for the rest.
  function automatic logic [63:0] unit_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[78:15];
      end
      4'b0011: begin
        if (b == 64'd0) return 64'd0;
        p = $signed({{49{a[63]}}, a, 15'd0}) / $signed({{64{b[63]}}, b});
        return p[63:0];
      end
      4'b0100: return a;
      default: return a ^ b;
    endcase
  endfunction

  assign fpu_res  = unit_model(fpu_op, fpu_a, fpu_b);
  assign fpu_res2 = unit_model(fpu_op2, fpu_a2, fpu_b2);

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] mon_e, mon_e2;
  int checks = 0;
  int errors = 0;
  int op3_bad = 0;
  int div_bad = 0;
  logic div_ok = 1'b0;
  int w0, w1, n;

  function automatic logic [W-1:0] pack(input logic id, input logic err, input logic nan, input logic [63:0] data);
    return {id, err, nan, data};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        fail_timeout("rsp_unexpected");
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {61'd0, rsp_id, rsp_err, rsp_nan, rsp_data}, {61'd0, mon_e});
      end
    end
    if (reset && fpu_op == 4'b0011 && !div_ok) op3_bad++;
    if (reset && fpu_busy && fpu_op != 4'b0011) div_bad++;
  end

  always @(negedge clk) begin
    if (reset && rsp_valid2 && rsp_ready2) begin
      if (exp2_q.size() == 0) begin
        fail_timeout("rsp2_unexpected");
      end else begin
        mon_e2 = exp2_q.pop_front();
        check("rsp2", {61'd0, rsp_id2, rsp_err2, rsp_nan2, rsp_data2}, {61'd0, mon_e2});
      end
    end
  end

  task automatic issue(input int idx, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output int waited);
    waited = 0;
    req_op[4*idx +: 4]  = op;
    req_a[64*idx +: 64] = a;
    req_b[64*idx +: 64] = b;
    req_valid[idx]      = 1'b1;
    @(negedge clk);
    while (!req_ready[idx] && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready[idx]) fail_timeout("grant");
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      fail_timeout("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!rsp_valid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    if (!rsp_valid) fail_timeout("rsp_valid");
  endtask

  task automatic wait_rsp_valid2(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!rsp_valid2 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    if (!rsp_valid2) fail_timeout("rsp_valid2");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; fpu_busy = 1'b0; rsp_ready = 1'b1;
    req_valid2 = '0; req_op2 = '0; req_a2 = '0; req_b2 = '0; fpu_busy2 = 1'b0; rsp_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {dbg_state, rsp_valid, req_ready, fpu_op, rsp_err, rsp_nan, rsp_id}, '0);
    check("reset_data", {fpu_a, fpu_b}, '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_state2", {dbg_state2, rsp_valid2}, '0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Both requesters MUL 1.5*2.0: id0 then id1; the accept cycle grants nothing.
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'h18000));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 64'h18000));
    fork
      issue(0, 4'b0010, 64'hC000, 64'h10000, w0);
      issue(1, 4'b0010, 64'hC000, 64'h10000, w1);
    join
    check("t2_first_grant_wait", 128'(w0), 128'd0);
    check("t2_second_grant_wait", 128'(w1), 128'd3);
    wait_drain();

    // Next both-valid round starts at id0 again.
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'h10000));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 64'hC000));
    fork
      issue(0, 4'b0000, 64'h8000, 64'h8000, w0);
      issue(1, 4'b0001, 64'h10000, 64'h4000, w1);
    join
    check("t2_round2_first_id0", 128'(w0), 128'd0);
    wait_drain();

    // Single ADD: ready in the request cycle, rsp_valid two cycles later.
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'h10000));
    issue(0, 4'b0000, 64'hC000, 64'h4000, w0);
    check("t1_ready_same_cycle", 128'(w0), 128'd0);
    @(negedge clk);
    check("t1_valid_after_1", 128'(rsp_valid), 128'd0);
    @(negedge clk);
    check("t1_valid_after_2", 128'(rsp_valid), 128'd1);
    wait_drain();

    // Divide with busy held 20 cycles.
    div_ok = 1'b1;
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 64'h10000));
    issue(1, 4'b0011, 64'h18000, 64'hC000, w0);
    @(negedge clk);
    check("t3_div_start_op", 128'(fpu_op), 128'h3);
    @(posedge clk);
    #1 fpu_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1 fpu_busy = 1'b0;
    @(negedge clk);
    check("t3_valid_busy_fall", 128'(rsp_valid), 128'd0);
    @(negedge clk);
    check("t3_valid_next", 128'(rsp_valid), 128'd1);
    wait_drain();
    div_ok = 1'b0;
    check("t3_op_while_busy", 128'(div_bad), 128'd0);

    // Illegal opcodes, a legal high opcode, and the saturated-result code.
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 64'h0));
    issue(0, 4'b0111, 64'h1234, 64'h5678, w0);
    wait_drain();
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 64'h0));
    issue(1, 4'b1111, 64'h1234, 64'h5678, w0);
    wait_drain();
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'hFF00));
    issue(0, 4'b1101, 64'hF0F0, 64'h0FF0, w0);
    wait_drain();
    exp_q.push_back(pack(1'b1, 1'b0, NAN_EN, 64'h8000_0000_0000_0000));
    issue(1, 4'b0100, 64'h8000_0000_0000_0000, 64'h0, w0);
    wait_drain();
    check("t4_no_stray_div_op", 128'(op3_bad), 128'd0);

    // Timeout instance: busy stuck high after launch, abort after 8 DIV_WAIT cycles.
    exp2_q.push_back(pack(1'b0, 1'b1, NAN_EN, 64'h0));
    req_op2[3:0] = 4'b0011; req_a2[63:0] = 64'h18000; req_b2[63:0] = 64'hC000;
    req_valid2[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready2[0] && n < 50) begin n++; @(negedge clk); end
    if (!req_ready2[0]) fail_timeout("t5_grant");
    @(posedge clk);
    #1 req_valid2[0] = 1'b0;
    @(negedge clk);
    check("t5_div_start_op", 128'(fpu_op2), 128'h3);
    @(posedge clk);
    #1 fpu_busy2 = 1'b1;
    wait_rsp_valid2(n);
    check("t5_timeout_cycles", 128'(n), 128'd8);

    // Stale busy holds the next divide in DIV_START; once it clears, busy never rises -> timeout.
    exp2_q.push_back(pack(1'b0, 1'b1, NAN_EN, 64'h0));
    @(posedge clk);
    #1 req_valid2[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready2[0] && n < 50) begin n++; @(negedge clk); end
    if (!req_ready2[0]) fail_timeout("t5_grant2");
    @(posedge clk);
    #1 req_valid2[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_stale_hold", {dbg_state2, fpu_op2}, {3'd2, 4'b0011});
    @(posedge clk);
    #1 fpu_busy2 = 1'b0;
    wait_rsp_valid2(n);
    check("t5_stale_timeout_cycles", 128'(n), 128'd9);
    n = 0;
    while (exp2_q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    if (exp2_q.size() != 0) fail_timeout("t5_drain");
    @(posedge clk);
    #1;

    // Stalled response holds its fields.
    rsp_ready = 1'b0;
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'h3000));
    issue(0, 4'b0000, 64'h1000, 64'h2000, w0);
    wait_rsp_valid(n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_stall_fields", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 1'b0, 1'b0, 64'h3000});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    // Reset mid-DIV_WAIT discards the op and returns rr_ptr to 0.
    div_ok = 1'b1;
    issue(1, 4'b0011, 64'h18000, 64'hC000, w0);
    @(negedge clk);
    @(posedge clk);
    #1 fpu_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 begin reset = 1'b0; fpu_busy = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_ctrl", {dbg_state, rsp_valid, req_ready, fpu_op, rsp_err, rsp_nan, rsp_id}, '0);
    check("t6_reset_data", {fpu_a, fpu_b}, '0);
    check("t6_reset_rsp_data", rsp_data, '0);
    @(posedge clk);
    #1 begin reset = 1'b1; div_ok = 1'b0; end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 64'h5000));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 64'h6000));
    fork
      issue(0, 4'b0000, 64'h2000, 64'h3000, w0);
      issue(1, 4'b0000, 64'h4000, 64'h2000, w1);
    join
    check("t6_rr_after_reset", 128'(w0), 128'd0);
    wait_drain();

    check("end_queue_empty", 128'(exp_q.size() + exp2_q.size()), 128'd0);
    check("end_no_stray_div_op", 128'(op3_bad), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
